jtag_axi_fifo_hs: RTL

Parametrised successor to the team's simple async-read FIFO. It wraps power-of-2 storage in valid/ready handshakes on both sides and adds a selectable registered output stage. It also provides programmable almost-full/almost-empty flags and a high-water-mark monitor. The block sits between the JTAG TAP clock-domain logic and the AXI master command/response paths, wherever back-pressure must be honoured rather than flagged as an error.

---
 rtl/jtag_axi_fifo_hs.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/jtag_axi_fifo_hs.sv
// rtl/jtag_axi_fifo_hs.sv - valid/ready FIFO with optional output register, level flags and high-water mark
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clear_i         synchronous flush (overrides everything except rst)
//   s_valid_i/s_ready_o/s_data_i   write side handshake
//   m_valid_o/m_ready_i/m_data_o   read side handshake (m_data_o is 0 when not valid)
//   ocup_o          entries held (storage + output register)
//   max_ocup_o      high-water mark of ocup_o since rst/clear
//   almost_full_o   ocup_o >= AFULL_TH
//   almost_empty_o  ocup_o <= AEMPTY_TH
module jtag_axi_fifo_hs #(
  parameter int SLOTS     = 4,
  parameter int WIDTH     = 32,
  parameter int OUT_REG   = 0,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1,
  localparam int CW       = $clog2(SLOTS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [CW-1:0]    ocup_o,
  output logic [CW-1:0]    max_ocup_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  localparam int AW  = $clog2(SLOTS);
  localparam int CAP = SLOTS + OUT_REG;
  localparam logic [CW-1:0] CAP_C    = CW'(CAP);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  generate
    if ((SLOTS < 2) || ((SLOTS & (SLOTS - 1)) != 0)) begin : g_bad_slots
      $error("jtag_axi_fifo_hs: SLOTS must be a power of 2 and >= 2");
    end
    if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_out_reg
      $error("jtag_axi_fifo_hs: OUT_REG must be 0 or 1");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > CAP)) begin : g_bad_afull
      $error("jtag_axi_fifo_hs: AFULL_TH must lie in 1..CAP");
    end
    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_aempty
      $error("jtag_axi_fifo_hs: AEMPTY_TH must be below AFULL_TH");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [SLOTS];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_max_ocup;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;

  logic [CW-1:0]    w_st_cnt;
  logic [CW-1:0]    w_ocup_raw;
  logic             w_st_empty;
  logic [WIDTH-1:0] w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_wr_en;
  logic             w_rd_en;

  always_comb begin
    // Pointers carry a wrap bit, so the difference is the storage count 0..SLOTS.
    w_st_cnt   = r_wr_ptr - r_rd_ptr;
    w_st_empty = (r_wr_ptr == r_rd_ptr);
    w_ocup_raw = w_st_cnt + {{(CW-1){1'b0}}, r_out_vld};
    w_head     = r_mem[r_rd_ptr[AW-1:0]];

    // Space depends on registered occupancy only: a pop in the same cycle
    // never opens room for a write.
    s_ready_o = (w_ocup_raw < CAP_C) & ~clear_i;

    if (OUT_REG != 0) begin
      m_valid_o = r_out_vld & ~clear_i;
      m_data_o  = m_valid_o ? r_out_data : '0;
    end else begin
      m_valid_o = ~w_st_empty & ~clear_i;
      m_data_o  = m_valid_o ? w_head : '0;
    end

    ocup_o         = clear_i ? '0 : w_ocup_raw;
    almost_full_o  = (ocup_o >= AFULL_C);
    almost_empty_o = (ocup_o <= AEMPTY_C);

    w_push = s_valid_i & s_ready_o;
    w_pop  = m_valid_o & m_ready_i;

    // Output register refills when it is empty or being consumed; storage
    // head has priority, otherwise an incoming word bypasses storage.
    w_load = ~r_out_vld | w_pop;
    if (OUT_REG != 0) begin
      w_rd_en = w_load & ~w_st_empty;
      w_wr_en = w_push & ~(w_load & w_st_empty);
    end else begin
      w_rd_en = w_pop;
      w_wr_en = w_push;
    end
  end

  assign max_ocup_o = r_max_ocup;

  // Storage array is not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_max_ocup <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_max_ocup <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + CW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
      if (w_ocup_raw > r_max_ocup) begin
        r_max_ocup <= w_ocup_raw;
      end
      if ((OUT_REG != 0) && w_load) begin
        if (!w_st_empty) begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_head;
        end else if (w_push) begin
          r_out_vld  <= 1'b1;
          r_out_data <= s_data_i;
        end else begin
          r_out_vld  <= 1'b0;
          r_out_data <= '0;
        end
      end
    end
  end

endmodule
